dlx_bus_slave: RTL and testbench
================================

DLX_BUS_SLAVE -- requirements
Module: dlx_bus_slave

Interface
REQ-001 Parameter WAIT_STATES, default 2, number of wait cycles between request capture and acknowledge (0..15).
REQ-002 Parameter ADDR_W, default 4, word-index width; memory depth is 2**ADDR_W words of 32 bits.
REQ-003 CLK_IN  input  1  single clock; all state updates on its rising edge.
REQ-004 RESET_N  input  1  reset, asynchronous and active-low.
REQ-005 AS_N  input  1  address strobe from the DLX master, active-low.
REQ-006 WR_N  input  1  transfer direction from the master: 0 write, 1 read.
REQ-007 ADDR  input  32  byte address; ADDR[ADDR_W+1:2] is the word index.
REQ-008 DIN  input  32  write data from the master.
REQ-009 DOUT  output  32  read data to the master.
REQ-010 ACK_N  output  1  transfer acknowledge to the master, active-low.
REQ-011 BUSERR  output  1  out-of-range access flag, active-high (see Configuration).

Function
REQ-012 The slave SHALL implement states IDLE, WAIT, ACK and RECOVER.
REQ-013 In IDLE, a rising edge with AS_N=0 SHALL latch ADDR and WR_N, load the wait counter with WAIT_STATES, and enter WAIT (or ACK directly when WAIT_STATES=0).
- Write data is not latched at this point.
REQ-014 In WAIT, the counter SHALL decrement once per cycle and the slave SHALL enter ACK on the edge where the counter reads 1.
REQ-015 In WAIT, if AS_N=1 is sampled, the slave SHALL return to IDLE with no acknowledge and no memory write (abort).
REQ-016 In ACK, ACK_N SHALL be 0 for exactly one cycle; on all other cycles ACK_N SHALL be 1.
- Acknowledge latency from the capture edge is WAIT_STATES+1 cycles.
REQ-017 In the ACK cycle of a read, DOUT SHALL hold mem[index]; DOUT SHALL hold its last value at all other times.
REQ-018 In the ACK cycle of a write, mem[index] SHALL be updated with DIN at the end of that cycle.
- DIN is therefore sampled in the ACK cycle, not at the capture edge.
REQ-019 After ACK, the slave SHALL enter RECOVER and remain there until AS_N=1 is sampled, then return to IDLE.
- A strobe held low SHALL never produce a second acknowledge.
REQ-020 An access with any of ADDR[31:ADDR_W+2] nonzero, or ADDR[1:0] nonzero, is out of range.
- A read SHALL return 0 and a write SHALL leave memory unchanged.
- The access SHALL still be acknowledged.
REQ-021 If AS_N=0 is sampled in the same cycle that RECOVER sees AS_N=1, that request SHALL be ignored; a new request is captured only from IDLE.

Reset
REQ-022 Assertion of RESET_N SHALL immediately force the state to IDLE, counter 0, ACK_N=1, DOUT=0, BUSERR=0 and all memory words to 0.
REQ-023 Reset mid-transfer SHALL abort the transfer with no acknowledge and no memory write.
REQ-024 Deassertion of RESET_N SHALL take effect on the next rising edge of CLK_IN.

Configuration
REQ-025 With macro DLX_SLAVE_BUSERR_EN defined, BUSERR SHALL be 1 during the ACK cycle of an out-of-range access and 0 otherwise.
REQ-026 Without DLX_SLAVE_BUSERR_EN, BUSERR SHALL be tied to 0 and no range-flag logic SHALL be built; REQ-020 data behaviour still applies.

Structure
REQ-027 The state enumeration, the WAIT_STATES default and the ADDR_W default SHALL reside in shared package dlx_bus_pkg.
REQ-028 The wait counter SHALL be a sub-module dlx_wait_cnt with load, decrement and terminal-count signals.

Verification
REQ-029 Reset, then a write of 0xDEADBEEF to ADDR 0x8 with WAIT_STATES=2:
- ACK_N is low exactly 3 cycles after capture, for 1 cycle.
- A following read of 0x8 returns 0xDEADBEEF in its ACK cycle.
REQ-030 AS_N held low for 10 cycles after a read -> exactly one ACK_N pulse; a new request is accepted only after AS_N returns to 1.
REQ-031 AS_N raised during WAIT on a write of 0x12345678 to ADDR 0x4 -> no ACK_N pulse; a read of 0x4 returns 0.
REQ-032 Write to ADDR 0x100 (ADDR_W=4):
- acknowledged, memory unchanged;
- BUSERR=1 in the ACK cycle with DLX_SLAVE_BUSERR_EN defined, 0 without it.
REQ-033 RESET_N asserted in WAIT of a write -> ACK_N stays 1, DOUT=0, and all words read back 0 after reset.
REQ-034 WAIT_STATES=0 -> ACK_N low on the cycle immediately after the capture edge.

Source files
------------

// File: rtl/dlx_bus_pkg.sv
// dlx_bus_pkg: shared FSM states, parameter defaults and address-range helper for the DLX bus slave
package dlx_bus_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_RECOVER
    } state_e;

    localparam int WAIT_STATES_DEF = 2;
    localparam int ADDR_W_DEF      = 4;
    localparam int CNT_W           = 4;

    // An access is in range when it is word-aligned and no bit above the word index is set
    function automatic logic addr_ok(input logic [31:0] a, input int aw);
        return ((a >> (aw + 2)) == 32'd0) && (a[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/dlx_wait_cnt.sv
// dlx_wait_cnt: loadable down-counter pacing the wait states; tc_o flags the last wait cycle
module dlx_wait_cnt #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic         dec_i,
    input  logic [W-1:0] val_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Load wins over decrement; the count saturates at zero
    always_comb cnt_d = load_i ? val_i : (dec_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;

    // Counter register, cleared by reset
    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) cnt_q <= '0;
        else cnt_q <= cnt_d;

    assign tc_o = (cnt_q == W'(1));

endmodule

// File: rtl/dlx_bus_slave.sv
// dlx_bus_slave: DLX bus memory slave with programmable wait states; BUSERR flag built only with DLX_SLAVE_BUSERR_EN
module dlx_bus_slave
    import dlx_bus_pkg::*;
#(
    parameter int WAIT_STATES = WAIT_STATES_DEF,
    parameter int ADDR_W      = ADDR_W_DEF
) (
    input  logic        CLK_IN,
    input  logic        RESET_N,
    input  logic        AS_N,
    input  logic        WR_N,
    input  logic [31:0] ADDR,
    input  logic [31:0] DIN,
    output logic [31:0] DOUT,
    output logic        ACK_N,
    output logic        BUSERR
);

    localparam int DEPTH = 2 ** ADDR_W;

    state_e            state_q;
    logic [31:0]       addr_q;
    logic              rd_q;
    logic              ack_n_q;
    logic [31:0]       dout_q;
    logic [31:0]       mem_q [DEPTH];
    logic              tc;
    logic              load;
    logic              dec;
    logic [31:0]       acc_addr;
    logic              acc_rd;
    logic              acc_ok;
    logic [ADDR_W-1:0] acc_idx;
    logic              go_ack;

    assign load = (state_q == S_IDLE) && !AS_N;
    assign dec  = (state_q == S_WAIT);

    dlx_wait_cnt #(.W(CNT_W)) u_cnt (
        .clk_i   (CLK_IN),
        .rst_n_i (RESET_N),
        .load_i  (load),
        .dec_i   (dec),
        .val_i   (CNT_W'(WAIT_STATES)),
        .tc_o    (tc)
    );

    // Access attributes come straight from the bus on a zero-wait capture, otherwise from the latched request
    always_comb begin
        acc_addr = (state_q == S_IDLE) ? ADDR : addr_q;
        acc_rd   = (state_q == S_IDLE) ? WR_N : rd_q;
        acc_ok   = addr_ok(acc_addr, ADDR_W);
        acc_idx  = acc_addr[ADDR_W+1:2];
        go_ack   = ((state_q == S_IDLE) && !AS_N && (WAIT_STATES == 0)) ||
                   ((state_q == S_WAIT) && !AS_N && tc);
    end

    // Transfer FSM with registered acknowledge and read data
    always_ff @(posedge CLK_IN or negedge RESET_N)
        if (!RESET_N) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rd_q    <= 1'b1;
            ack_n_q <= 1'b1;
            dout_q  <= '0;
        end else begin
            ack_n_q <= !go_ack;
            if (go_ack && acc_rd) dout_q <= acc_ok ? mem_q[acc_idx] : 32'd0;
            case (state_q)
                S_IDLE:
                    if (!AS_N) begin
                        addr_q  <= ADDR;
                        rd_q    <= WR_N;
                        state_q <= (WAIT_STATES == 0) ? S_ACK : S_WAIT;
                    end
                S_WAIT:    state_q <= AS_N ? S_IDLE : (tc ? S_ACK : S_WAIT);
                S_ACK:     state_q <= S_RECOVER;
                S_RECOVER: state_q <= AS_N ? S_IDLE : S_RECOVER;
                default:   state_q <= S_IDLE;
            endcase
        end

    // Memory array; write data is taken from DIN at the end of the acknowledge cycle
    always_ff @(posedge CLK_IN or negedge RESET_N)
        if (!RESET_N) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (state_q == S_ACK && !rd_q && addr_ok(addr_q, ADDR_W)) begin
            mem_q[addr_q[ADDR_W+1:2]] <= DIN;
        end

`ifdef DLX_SLAVE_BUSERR_EN
    logic buserr_q;

    // Range flag shown only during the acknowledge cycle of an out-of-range access
    always_ff @(posedge CLK_IN or negedge RESET_N)
        if (!RESET_N) buserr_q <= 1'b0;
        else buserr_q <= go_ack && !acc_ok;

    assign BUSERR = buserr_q;
`else
    assign BUSERR = 1'b0;
`endif

    assign ACK_N = ack_n_q;
    assign DOUT  = dout_q;

endmodule

// File: tb/tb_dlx_bus_slave.sv
// tb_dlx_bus_slave: randomized self-checking bench for dlx_bus_slave (WAIT_STATES=2 and WAIT_STATES=0 instances)
module tb_dlx_bus_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        as_n [2];
    logic        wr_n [2];
    logic [31:0] addr [2];
    logic [31:0] din [2];
    logic [31:0] dout [2];
    logic        ack_n [2];
    logic        buserr [2];

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_m [2][16];
    logic [31:0] last_m [2];

    always #5 clk = ~clk;

    dlx_bus_slave #(.WAIT_STATES(2), .ADDR_W(4)) dut (
        .CLK_IN(clk), .RESET_N(rst_n), .AS_N(as_n[0]), .WR_N(wr_n[0]), .ADDR(addr[0]),
        .DIN(din[0]), .DOUT(dout[0]), .ACK_N(ack_n[0]), .BUSERR(buserr[0])
    );

    dlx_bus_slave #(.WAIT_STATES(0), .ADDR_W(4)) dut_ws0 (
        .CLK_IN(clk), .RESET_N(rst_n), .AS_N(as_n[1]), .WR_N(wr_n[1]), .ADDR(addr[1]),
        .DIN(din[1]), .DOUT(dout[1]), .ACK_N(ack_n[1]), .BUSERR(buserr[1])
    );

    function automatic bit in_rng(input logic [31:0] a);
        return (a < 32'd64) && (a % 4 == 0);
    endfunction

    function automatic int lat_of(input int s);
        return (s == 0) ? 3 : 1;
    endfunction

    function automatic logic be_of(input logic [31:0] a);
`ifdef DLX_SLAVE_BUSERR_EN
        return !in_rng(a);
`else
        return 1'b0 & a[0];
`endif
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            last_m[s] = 32'd0;
            for (int i = 0; i < 16; i++) mem_m[s][i] = 32'd0;
        end
    endtask

    task automatic model_xfer(input int s, input logic w, input logic [31:0] a, input logic [31:0] d);
        if (w) last_m[s] = in_rng(a) ? mem_m[s][a / 4] : 32'd0;
        else if (in_rng(a)) mem_m[s][a / 4] = d;
    endtask

    // Drives one complete transfer from a negedge and reports what the slave did
    task automatic xfer(input int s, input logic w, input logic [31:0] a, input logic [31:0] d, input int hold,
                        output int lat, output logic [31:0] rd, output logic be, output int extra,
                        output logic [31:0] after);
        lat = -1;
        rd = 32'hx;
        be = 1'bx;
        extra = 0;
        as_n[s] = 1'b0;
        wr_n[s] = w;
        addr[s] = a;
        din[s] = ~d;
        @(posedge clk);
        for (int n = 1; n <= 20 && lat < 0; n++) begin
            @(negedge clk);
            din[s] = d;
            if (ack_n[s] === 1'b0) begin
                lat = n;
                rd = dout[s];
                be = buserr[s];
            end
        end
        for (int k = 0; k <= hold; k++) begin
            @(negedge clk);
            if (ack_n[s] !== 1'b1 || buserr[s] !== 1'b0) extra++;
        end
        as_n[s] = 1'b1;
        addr[s] = $urandom;
        wr_n[s] = 1'($urandom);
        @(negedge clk);
        if (ack_n[s] !== 1'b1 || buserr[s] !== 1'b0) extra++;
        after = dout[s];
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (ack_n[s] !== 1'b1) begin errors++; $display("FAIL reset_ack s=%0d got %b exp 1", s, ack_n[s]); end
            checks++;
            if (dout[s] !== 32'd0) begin errors++; $display("FAIL reset_dout s=%0d got %h exp 0", s, dout[s]); end
            checks++;
            if (buserr[s] !== 1'b0) begin errors++; $display("FAIL reset_buserr s=%0d got %b exp 0", s, buserr[s]); end
        end
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        checks++;
        if (ack_n[0] !== 1'b1) begin errors++; $display("FAIL post_reset_ack got %b exp 1", ack_n[0]); end
    endtask

    task automatic test_write_read();
        int lat, extra;
        logic [31:0] rd, after;
        logic be;
        xfer(0, 1'b0, 32'h8, 32'hDEADBEEF, 0, lat, rd, be, extra, after);
        model_xfer(0, 1'b0, 32'h8, 32'hDEADBEEF);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL wr_latency got %0d exp 3", lat); end
        checks++;
        if (extra !== 0) begin errors++; $display("FAIL wr_pulse extra=%0d exp 0", extra); end
        xfer(0, 1'b1, 32'h8, 32'h0, 0, lat, rd, be, extra, after);
        model_xfer(0, 1'b1, 32'h8, 32'h0);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL rd_latency got %0d exp 3", lat); end
        checks++;
        if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h exp DEADBEEF", rd); end
        checks++;
        if (after !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_hold got %h exp DEADBEEF", after); end
    endtask

    task automatic test_hold_strobe();
        int lat, extra;
        logic [31:0] rd, after;
        logic be;
        xfer(0, 1'b1, 32'h8, 32'h0, 10, lat, rd, be, extra, after);
        model_xfer(0, 1'b1, 32'h8, 32'h0);
        checks++;
        if (lat !== 3 || extra !== 0) begin errors++; $display("FAIL hold_single_ack lat=%0d extra=%0d exp 3/0", lat, extra); end
        xfer(0, 1'b1, 32'h8, 32'h0, 0, lat, rd, be, extra, after);
        model_xfer(0, 1'b1, 32'h8, 32'h0);
        checks++;
        if (lat !== 3 || rd !== 32'hDEADBEEF) begin errors++; $display("FAIL hold_next_req lat=%0d data=%h exp 3/DEADBEEF", lat, rd); end
    endtask

    task automatic test_abort();
        int lat, extra;
        int acks = 0;
        logic [31:0] rd, after;
        logic be;
        as_n[0] = 1'b0;
        wr_n[0] = 1'b0;
        addr[0] = 32'h4;
        din[0] = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        as_n[0] = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (ack_n[0] !== 1'b1) acks++;
        end
        checks++;
        if (acks !== 0) begin errors++; $display("FAIL abort_ack got %0d pulses exp 0", acks); end
        xfer(0, 1'b1, 32'h4, 32'h0, 0, lat, rd, be, extra, after);
        model_xfer(0, 1'b1, 32'h4, 32'h0);
        checks++;
        if (lat !== 3 || rd !== 32'h0) begin errors++; $display("FAIL abort_mem lat=%0d data=%h exp 3/0", lat, rd); end
    endtask

    task automatic test_out_of_range();
        int lat, extra;
        logic [31:0] rd, after;
        logic be;
        xfer(0, 1'b0, 32'h0, 32'hA5A5A5A5, 0, lat, rd, be, extra, after);
        model_xfer(0, 1'b0, 32'h0, 32'hA5A5A5A5);
        xfer(0, 1'b0, 32'h100, 32'h11111111, 0, lat, rd, be, extra, after);
        model_xfer(0, 1'b0, 32'h100, 32'h11111111);
        checks++;
        if (lat !== 3 || extra !== 0) begin errors++; $display("FAIL oor_ack lat=%0d extra=%0d exp 3/0", lat, extra); end
        checks++;
        if (be !== be_of(32'h100)) begin errors++; $display("FAIL oor_buserr got %b exp %b", be, be_of(32'h100)); end
        xfer(0, 1'b0, 32'h9, 32'h22222222, 0, lat, rd, be, extra, after);
        model_xfer(0, 1'b0, 32'h9, 32'h22222222);
        checks++;
        if (be !== be_of(32'h9)) begin errors++; $display("FAIL misalign_buserr got %b exp %b", be, be_of(32'h9)); end
        xfer(0, 1'b1, 32'h0, 32'h0, 0, lat, rd, be, extra, after);
        model_xfer(0, 1'b1, 32'h0, 32'h0);
        checks++;
        if (rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL oor_mem0 got %h exp A5A5A5A5", rd); end
        xfer(0, 1'b1, 32'h8, 32'h0, 0, lat, rd, be, extra, after);
        model_xfer(0, 1'b1, 32'h8, 32'h0);
        checks++;
        if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL misalign_mem8 got %h exp DEADBEEF", rd); end
        xfer(0, 1'b1, 32'h100, 32'h0, 0, lat, rd, be, extra, after);
        model_xfer(0, 1'b1, 32'h100, 32'h0);
        checks++;
        if (rd !== 32'h0 || lat !== 3) begin errors++; $display("FAIL oor_read data=%h lat=%0d exp 0/3", rd, lat); end
    endtask

    task automatic test_zero_wait();
        int lat, extra;
        logic [31:0] rd, after;
        logic be;
        xfer(1, 1'b0, 32'h3C, 32'hCAFEF00D, 0, lat, rd, be, extra, after);
        model_xfer(1, 1'b0, 32'h3C, 32'hCAFEF00D);
        checks++;
        if (lat !== 1 || extra !== 0) begin errors++; $display("FAIL ws0_wr lat=%0d extra=%0d exp 1/0", lat, extra); end
        xfer(1, 1'b1, 32'h3C, 32'h0, 0, lat, rd, be, extra, after);
        model_xfer(1, 1'b1, 32'h3C, 32'h0);
        checks++;
        if (lat !== 1 || rd !== 32'hCAFEF00D) begin errors++; $display("FAIL ws0_rd lat=%0d data=%h exp 1/CAFEF00D", lat, rd); end
    endtask

    task automatic test_random();
        int lat, extra, hold, s, kind;
        logic [31:0] rd, after, a, d;
        logic be, w;
        for (int i = 0; i < 60; i++) begin
            s = int'($urandom_range(0, 1));
            w = 1'($urandom);
            d = $urandom;
            hold = int'($urandom_range(0, 3));
            kind = int'($urandom_range(0, 9));
            a = (kind == 0) ? ($urandom | 32'h40) :
                (kind == 1) ? {26'd0, 4'($urandom), 2'($urandom_range(1, 3))} :
                              {26'd0, 4'($urandom), 2'b00};
            xfer(s, w, a, d, hold, lat, rd, be, extra, after);
            model_xfer(s, w, a, d);
            checks++;
            if (lat !== lat_of(s)) begin errors++; $display("FAIL rnd_lat i=%0d s=%0d got %0d exp %0d", i, s, lat, lat_of(s)); end
            checks++;
            if (rd !== last_m[s]) begin errors++; $display("FAIL rnd_dout i=%0d s=%0d a=%h got %h exp %h", i, s, a, rd, last_m[s]); end
            checks++;
            if (be !== be_of(a)) begin errors++; $display("FAIL rnd_buserr i=%0d a=%h got %b exp %b", i, a, be, be_of(a)); end
            checks++;
            if (extra !== 0 || after !== last_m[s]) begin errors++; $display("FAIL rnd_after i=%0d extra=%0d dout=%h exp 0/%h", i, extra, after, last_m[s]); end
        end
    endtask

    task automatic test_reset_mid();
        int lat, extra;
        int acks = 0;
        logic [31:0] rd, after;
        logic be;
        xfer(0, 1'b0, 32'h20, 32'h5A5A0001, 0, lat, rd, be, extra, after);
        xfer(0, 1'b1, 32'h20, 32'h0, 0, lat, rd, be, extra, after);
        as_n[0] = 1'b0;
        wr_n[0] = 1'b0;
        addr[0] = 32'h24;
        din[0] = 32'h77778888;
        @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (ack_n[s] !== 1'b1 || dout[s] !== 32'd0 || buserr[s] !== 1'b0) begin
                errors++;
                $display("FAIL midreset_out s=%0d ack=%b dout=%h be=%b exp 1/0/0", s, ack_n[s], dout[s], buserr[s]);
            end
        end
        as_n[0] = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (ack_n[0] !== 1'b1) acks++;
        end
        rst_n = 1'b1;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            if (ack_n[0] !== 1'b1) acks++;
        end
        checks++;
        if (acks !== 0) begin errors++; $display("FAIL midreset_ack got %0d pulses exp 0", acks); end
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 16; i++) begin
                xfer(s, 1'b1, 32'(i * 4), 32'h0, 0, lat, rd, be, extra, after);
                model_xfer(s, 1'b1, 32'(i * 4), 32'h0);
                checks++;
                if (rd !== 32'd0 || lat !== lat_of(s)) begin
                    errors++;
                    $display("FAIL midreset_word s=%0d w=%0d data=%h lat=%0d exp 0/%0d", s, i, rd, lat, lat_of(s));
                end
            end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            as_n[s] = 1'b1;
            wr_n[s] = 1'b1;
            addr[s] = 32'd0;
            din[s] = 32'd0;
        end
        model_reset();
        test_reset();
        test_write_read();
        test_hold_strobe();
        test_abort();
        test_out_of_range();
        test_zero_wait();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
